// File: rtl/eth_type_dispatch_pkg.sv
// rtl/eth_type_dispatch_pkg.sv - shared states, selections and widths for the Ethernet type dispatcher
package eth_type_dispatch_pkg;

  localparam int CNT_W  = 11;
  localparam int FCNT_W = 16;

  localparam logic [7:0] DEF_TYPE_ONE   = 8'h01;
  localparam logic [7:0] DEF_TYPE_TWO   = 8'h02;
  localparam logic [7:0] DEF_TYPE_THREE = 8'h03;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    HUNT,
    FWD,
    DROP
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ONE,
    SEL_TWO,
    SEL_THREE
  } sel_e;

endpackage

// File: rtl/eth_type_dispatch_delay.sv
// rtl/eth_type_dispatch_delay.sv - DEPTH-stage {dv, data} shift register with synchronous clear
module byte_delay_line #(
  parameter int DEPTH = 13
) (
  input  logic       clock,
  input  logic       sclr,
  input  logic       dv_i,
  input  logic [7:0] data_i,
  output logic       dv_o,
  output logic [7:0] data_o,
  output logic       dv_next_o,
  output logic       any_dv_o
);

  logic [DEPTH-1:0][8:0] stage_q;

  always_ff @(posedge clock) begin
    if (sclr) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], {dv_i, data_i}};
    end
  end

  assign {dv_o, data_o} = stage_q[DEPTH-1];
  // dv of the byte that reaches the output next cycle; lets the top spot a frame's last byte
  assign dv_next_o = stage_q[DEPTH-2][8];

  always_comb begin
    any_dv_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_dv_o = any_dv_o | stage_q[i][8];
    end
  end

endmodule

// File: rtl/eth_type_dispatch.sv
// rtl/eth_type_dispatch.sv - classifies frames by type byte and gates delayed data to one of three parsers
module eth_type_dispatch
  import eth_type_dispatch_pkg::*;
#(
  parameter int         TYPE_OFFSET = 12,
  parameter int         MAX_LEN     = 1024,
  parameter logic [7:0] TYPE_ONE    = DEF_TYPE_ONE,
  parameter logic [7:0] TYPE_TWO    = DEF_TYPE_TWO,
  parameter logic [7:0] TYPE_THREE  = DEF_TYPE_THREE
) (
  input  logic              clock,
  input  logic              sclr,
  input  logic [7:0]        rx_data,
  input  logic              rx_dv,
  output logic [7:0]        data_out,
  output logic              ena_one,
  output logic              ena_two,
  output logic              ena_three,
  output logic [FCNT_W-1:0] frames_ok,
  output logic [FCNT_W-1:0] frames_drop,
  output logic              busy
);

  localparam int               D          = TYPE_OFFSET + 1;
  localparam logic [CNT_W-1:0] OFFSET_IDX = CNT_W'(TYPE_OFFSET);
  localparam logic [CNT_W-1:0] MAX_IDX    = CNT_W'(MAX_LEN);

  state_e            state_q, state_d;
  sel_e              hit_sel, new_sel, out_sel_q, out_sel_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [FCNT_W-1:0] ok_q, drop_q;
  logic              drop_inc, ok_inc, ena_fwd;
  logic              dv_in, dv_out, dv_next, any_dv;

  // Bytes of a frame caught mid-flight by reset never mark the delay line as frame data
  assign dv_in = rx_dv && (state_q != WAIT_IDLE);

  byte_delay_line #(.DEPTH(D)) u_delay (
    .clock     (clock),
    .sclr      (sclr),
    .dv_i      (dv_in),
    .data_i    (rx_data),
    .dv_o      (dv_out),
    .data_o    (data_out),
    .dv_next_o (dv_next),
    .any_dv_o  (any_dv)
  );

  always_comb begin
    hit_sel = SEL_NONE;
    if (rx_data == TYPE_ONE)        hit_sel = SEL_ONE;
    else if (rx_data == TYPE_TWO)   hit_sel = SEL_TWO;
    else if (rx_data == TYPE_THREE) hit_sel = SEL_THREE;
  end

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    new_sel  = SEL_NONE;
    drop_inc = 1'b0;
    case (state_q)
      WAIT_IDLE: if (!rx_dv) state_d = IDLE;
      IDLE: begin
        in_cnt_d = '0;
        if (rx_dv) begin
          state_d  = HUNT;
          in_cnt_d = CNT_W'(1);
        end
      end
      HUNT: begin
        if (!rx_dv) begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end else begin
          in_cnt_d = (in_cnt_q < MAX_IDX) ? in_cnt_q + 1'b1 : in_cnt_q;
          if (in_cnt_q == OFFSET_IDX) begin
            if (hit_sel != SEL_NONE) begin
              state_d = FWD;
              new_sel = hit_sel;
            end else begin
              state_d  = DROP;
              drop_inc = 1'b1;
            end
          end
        end
      end
      FWD: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else if (in_cnt_q == MAX_IDX) begin
          state_d  = DROP;
          drop_inc = 1'b1;
        end else begin
          in_cnt_d = in_cnt_q + 1'b1;
        end
      end
      DROP: begin
        if (!rx_dv) state_d = IDLE;
        else in_cnt_d = (in_cnt_q < MAX_IDX) ? in_cnt_q + 1'b1 : in_cnt_q;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Output side: the selection is decided exactly one cycle before byte 0 leaves the delay line
  always_comb begin
    out_cnt_d = '0;
    if (dv_out) out_cnt_d = (out_cnt_q < MAX_IDX) ? out_cnt_q + 1'b1 : out_cnt_q;
    out_sel_d = dv_out ? out_sel_q : SEL_NONE;
    if (new_sel != SEL_NONE) out_sel_d = new_sel;
    ena_fwd   = dv_out && (out_cnt_q < MAX_IDX);
    ena_one   = ena_fwd && (out_sel_q == SEL_ONE);
    ena_two   = ena_fwd && (out_sel_q == SEL_TWO);
    ena_three = ena_fwd && (out_sel_q == SEL_THREE);
    ok_inc    = ena_fwd && (out_sel_q != SEL_NONE) && !dv_next;
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q   <= WAIT_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      out_sel_q <= SEL_NONE;
      ok_q      <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      out_sel_q <= out_sel_d;
      if (ok_inc)   ok_q   <= ok_q + 1'b1;
      if (drop_inc) drop_q <= drop_q + 1'b1;
    end
  end

  assign frames_ok   = ok_q;
  assign frames_drop = drop_q;
  assign busy        = (state_q == HUNT) || (state_q == FWD) || (state_q == DROP) || any_dv;

endmodule

// File: doc/eth_type_dispatch.md
ETH_TYPE_DISPATCH -- requirements
Module: eth_type_dispatch

Interface
REQ-001 The block SHALL have these parameters: TYPE_OFFSET, default 12, byte index of the packet-type byte within a frame.
REQ-002 The block SHALL have the parameter MAX_LEN, default 1024, the maximum number of frame bytes forwarded.
REQ-003 The block SHALL have the parameters TYPE_ONE, TYPE_TWO and TYPE_THREE, defaults 8'h01, 8'h02 and 8'h03, the type codes.
REQ-004 clock  input  1  single system clock; all logic on its rising edge.
REQ-005 sclr  input  1  reset, synchronous to clock and active-high.
REQ-006 rx_data  input  8  receive byte, valid when rx_dv is high.
REQ-007 rx_dv  input  1  frame-active strobe, one byte per clock while high; frames are separated by at least 1 low cycle.
REQ-008 data_out  output  8  rx_data delayed by D = TYPE_OFFSET+1 cycles, shared by all parsers.
REQ-009 ena_one / ena_two / ena_three  output  1 each  one-hot enables for the type ONE/TWO/THREE parsers.
REQ-010 frames_ok  output  16  count of frames forwarded to any parser; wraps.
REQ-011 frames_drop  output  16  count of frames that were short, of unknown type or oversize; wraps.
REQ-012 busy  output  1  high while any frame byte is in the block or is being forwarded.

Function
REQ-013 data_out SHALL equal rx_data from exactly D cycles earlier, whether or not any enable is high.
REQ-014 The FSM SHALL have the states WAIT_IDLE, IDLE, HUNT, FWD and DROP.
REQ-015 WAIT_IDLE SHALL wait for rx_dv low and then move to IDLE; IDLE SHALL move to HUNT on rx_dv high, taking that byte as byte 0.
REQ-016 HUNT SHALL count input bytes; at byte index TYPE_OFFSET it SHALL compare rx_data with the three type codes.
REQ-017 On a match, HUNT SHALL go to FWD and latch the selected output; with no match, it SHALL go to DROP.
REQ-018 If rx_dv falls in HUNT before byte TYPE_OFFSET arrives, the frame is short: frames_drop SHALL increment by 1 and the FSM SHALL return to IDLE.
REQ-019 The selected ena_x SHALL be high exactly in the cycles where data_out carries byte 0 through the last byte of the frame, capped at byte MAX_LEN-1; no cycle early or late.
REQ-020 At most one ena_x SHALL be high in any cycle; the other two SHALL stay low.
REQ-021 After the last forwarded byte, ena_x SHALL be low for at least 1 cycle, so that each parser's counter clears between frames.
REQ-022 A frame longer than MAX_LEN bytes SHALL have ena_x drop after output byte MAX_LEN-1.
REQ-023 Such an oversize frame SHALL increment frames_drop, not frames_ok; the FSM SHALL stay in DROP until rx_dv goes low.
REQ-024 frames_ok SHALL increment once per frame forwarded in full, in the cycle after its last output byte.
REQ-025 Frames separated by exactly 1 idle cycle SHALL both be handled correctly: the second frame's HUNT SHALL overlap the first frame's drain from the delay line.
REQ-026 When an increment of frames_ok and of frames_drop fall in the same cycle, both SHALL take effect.
REQ-027 The input byte counter SHALL be 11 bits and SHALL saturate at MAX_LEN; it SHALL never wrap within a frame.
REQ-028 Unknown type bytes and frames in DROP SHALL never assert any ena_x.

Reset
REQ-029 On sclr high, in the next cycle: all ena_x = 0, data_out = 0, busy = 0, frames_ok = 0, frames_drop = 0, byte counter = 0, and the delay line cleared to data 0 / dv 0.
REQ-030 On sclr the FSM SHALL go to WAIT_IDLE, so that a frame already in progress when reset is released is discarded and not counted.
REQ-031 sclr SHALL take priority over every other input in every state.

Structure
REQ-032 A shared package SHALL hold: the FSM state enumeration, the default type-code constants, and the counter width constants.
REQ-033 One sub-module, byte_delay_line, SHALL be instantiated: a parameterised D-stage shift register of {dv, data[7:0]} with synchronous clear.
REQ-034 The FSM, the enable-timing logic and the counters SHALL live in eth_type_dispatch itself.

Verification
REQ-035 Type ONE frame, 524 bytes, byte 12 = 8'h01, with an ena_one-driven type ONE parser attached -> ena_one high for 524 consecutive cycles starting when data_out = byte 0; frames_ok = 1; the parser writes 200 words.
REQ-036 Frame with byte 12 = 8'h55 -> no ena_x ever high; frames_drop = 1; data_out still mirrors the input with D = 13.
REQ-037 8-byte frame -> frames_drop = 1; FSM back in IDLE; no enable asserted.
REQ-038 Type TWO frame of 100 bytes, 1 idle cycle, then a type THREE frame of 100 bytes -> ena_two high for 100 cycles, exactly 1 low cycle, then ena_three high for 100 cycles; frames_ok = 2.
REQ-039 1500-byte type ONE frame -> ena_one high for 1024 cycles only; frames_drop = 1; frames_ok = 0.
REQ-040 sclr pulsed at byte 50 of a type ONE frame -> all outputs 0 in the next cycle; the rest of that frame is ignored; the next frame is forwarded normally.
